zm_div: RTL and testbench
=========================

Name: zm_div

Overview:
- Multi-cycle integer divide unit for the RV32M DIV/DIVU/REM/REMU instructions. It is the shift-and-subtract counterpart of the shift-and-add Zba datapath.
- Sits in the execute stage beside the ALU and bit-manipulation units.
- Accepts one operation through a valid/ready handshake, iterates one quotient bit per cycle, and returns the result with a one-cycle done pulse.
- Supports pipeline flush.

Parameters:
- XLEN, 32, operand and result width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start_valid  input  1  request to begin an operation.
- start_ready  output  1  unit idle; high when state is IDLE.
- flush  input  1  abort any in-flight operation.
- funct3  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU.
- funct7  input  7  must be 0000001 for a valid op.
- reg1  input  XLEN  dividend (rs1).
- reg2  input  XLEN  divisor (rs2).
- out  output  XLEN  result, registered.
- done  output  1  result valid, one-cycle pulse.
- busy  output  1  operation in flight (state CALC or DONE).

Behaviour:
- Reset: one clock, synchronous, active-high. On reset: state IDLE, out=0, done=0, busy=0, start_ready=1. Reset overrides flush and start_valid.
- Accept: an operation is accepted at an edge where start_valid && start_ready; call that edge E0. Operands, funct3, funct7 are latched at E0. start_valid while not ready is ignored; it is not queued.
- States:
  - IDLE: start_ready=1.
  - CALC: iteration count 0..XLEN-1.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Normal path (DIV/REM signed; DIVU/REMU unsigned):
  - At E0, signed ops take the absolute value of each operand; the result signs are recorded.
  - Restoring division, one bit per edge at E1..E_XLEN:
    - rem = {rem[XLEN-2:0], dvd[MSB]}
    - dvd shifted left by 1
    - if rem >= divisor: subtract, quotient bit = 1.
  - At E_XLEN, sign correction is applied:
    - quotient negated when the operand signs differ.
    - remainder takes the sign of the dividend.
  - out is loaded at E_XLEN and the state moves to DONE. done is high in the cycle after E_XLEN (latency XLEN+1 cycles).
- Special cases, resolved at E0 with a direct move to DONE (done high in the cycle after E0):
  - Divisor zero: quotient = all ones (both signednesses); remainder = dividend.
  - Signed overflow, dividend = 0x80000000 and divisor = 0xFFFFFFFF, DIV/REM only: quotient = 0x80000000, remainder = 0.
  - funct7 != 0000001 or funct3[2]=0: out=0.
- out holds its value after DONE until the next completion or reset.
- done is never high in two consecutive cycles.
- A back-to-back op may be accepted in the IDLE cycle following DONE.
- Flush:
  - If asserted at any edge while in CALC or DONE: next state IDLE, done=0, out unchanged.
  - Flush in DONE suppresses nothing already pulsed: done for that cycle is already visible.
  - Flush together with start_valid in IDLE: the start is ignored.
- Reset mid-operation: the operation is discarded and no done is produced.

Decomposition:
- Package zm_pkg:
  - funct3 constants: F3_DIV, F3_DIVU, F3_REM, F3_REMU.
  - F7_MULDIV constant.
  - state enum: IDLE, CALC, DONE.
  - XLEN default.
- Combinational sub-module zm_div_step: one restoring iteration.
  - Inputs: rem, dvd, divisor.
  - Outputs: next rem, next dvd, quotient bit.
  - Instantiated once and reused each cycle; it is not unrolled.

Test Plan:
- DIVU reg1=100, reg2=7 -> done exactly 33 cycles after the accept edge; out=14. REMU with the same operands -> out=2.
- DIV reg1=0xFFFFFFF9 (-7), reg2=2 -> out=0xFFFFFFFD (-3). REM with the same operands -> out=0xFFFFFFFF (-1).
- DIVU 5/0 -> out=0xFFFFFFFF. REMU 5/0 -> out=5. Both with done one cycle after accept.
- DIV 0x80000000 / 0xFFFFFFFF -> out=0x80000000. REM with the same operands -> out=0. Both at 1-cycle latency.
- Flush during CALC:
  - Start DIVU 100/7 and assert flush at iteration 10 -> no done pulse; start_ready=1 the next cycle; out keeps its prior value.
  - A new DIVU 9/3 accepted afterwards -> out=3.
- start_valid held high through a busy operation -> only one done per accepted op, and the second op is accepted in the IDLE cycle after DONE.
- Reset asserted mid-CALC -> out=0, done=0, busy=0 at the next edge.

Source files
------------

// File: rtl/zm_pkg.sv
// zm_pkg: shared constants and types for the zm_div integer divide unit.
//   F3_*       RV32M funct3 encodings handled by the divider
//   F7_MULDIV  funct7 value marking an M-extension op
//   state_e    divider control state
//   op_ctl_t   per-operation sign/selection flags latched at accept
package zm_pkg;

   localparam int unsigned XLEN_DEFAULT = 32;

   localparam logic [2:0] F3_DIV  = 3'b100;
   localparam logic [2:0] F3_DIVU = 3'b101;
   localparam logic [2:0] F3_REM  = 3'b110;
   localparam logic [2:0] F3_REMU = 3'b111;

   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef struct packed {
      logic neg_q;   // negate the quotient at the end
      logic neg_r;   // negate the remainder at the end
      logic is_rem;  // return remainder instead of quotient
   } op_ctl_t;

endpackage

// File: rtl/zm_div_if.sv
// zm_div_if: request/response bundle between the execute stage and zm_div.
//   master (execute stage): start_valid, flush, funct3, funct7, reg1, reg2 out;
//                           start_ready, out, done, busy in
//   slave  (divider):       the mirror image
interface zm_div_if #(
   parameter int unsigned XLEN = zm_pkg::XLEN_DEFAULT
);
   logic            start_valid;
   logic            start_ready;
   logic            flush;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [XLEN-1:0] reg1;
   logic [XLEN-1:0] reg2;
   logic [XLEN-1:0] out;
   logic            done;
   logic            busy;

   modport master (
      output start_valid, flush, funct3, funct7, reg1, reg2,
      input  start_ready, out, done, busy
   );

   modport slave (
      input  start_valid, flush, funct3, funct7, reg1, reg2,
      output start_ready, out, done, busy
   );
endinterface

// File: rtl/zm_div_step.sv
// zm_div_step: one restoring-division iteration (combinational).
//   rem_i/dvd_i/dvs_i  partial remainder, remaining dividend bits, divisor
//   rem_o/dvd_o        updated partial remainder and dividend shifted left
//   qbit_o             quotient bit produced by this iteration
module zm_div_step #(
   parameter int unsigned XLEN = zm_pkg::XLEN_DEFAULT
) (
   input  logic [XLEN-1:0] rem_i,
   input  logic [XLEN-1:0] dvd_i,
   input  logic [XLEN-1:0] dvs_i,
   output logic [XLEN-1:0] rem_o,
   output logic [XLEN-1:0] dvd_o,
   output logic            qbit_o
);
   // Keep the bit shifted out of rem: with divisors above 2^(XLEN-1) the
   // shifted remainder can exceed XLEN bits and must still compare correctly.
   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   assign shifted = {rem_i, dvd_i[XLEN-1]};
   assign diff    = shifted - {1'b0, dvs_i};
   assign qbit_o  = (shifted >= {1'b0, dvs_i});
   assign rem_o   = qbit_o ? diff[XLEN-1:0] : shifted[XLEN-1:0];
   assign dvd_o   = {dvd_i[XLEN-2:0], 1'b0};

   // The dropped top bits are zero whenever they are discarded.
   logic unused_hi;
   assign unused_hi = diff[XLEN] ^ shifted[XLEN];
endmodule

// File: rtl/zm_div.sv
// zm_div: multi-cycle RV32M DIV/DIVU/REM/REMU unit, one quotient bit per clock.
//   clk, reset  rising-edge clock, synchronous active-high reset
//   bus         zm_div_if slave: start handshake, flush, opcode, operands,
//               registered result, done pulse, busy flag
module zm_div
   import zm_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEFAULT
) (
   input logic     clk,
   input logic     reset,
   zm_div_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(XLEN - 1);

   state_e          state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] dvd_q, dvd_d;
   logic [XLEN-1:0] dvs_q, dvs_d;
   op_ctl_t         ctl_q, ctl_d;
   logic [XLEN-1:0] out_q, out_d;
   logic            done_q, busy_q, ready_q;

   logic [XLEN-1:0] step_rem, step_dvd;
   logic            step_qbit;

   logic            is_signed, is_rem, a_neg, b_neg;
   logic            valid_op, div0, ovf, special, accept;
   logic [XLEN-1:0] a_abs, b_abs, spec_res;
   logic [XLEN-1:0] q_raw, q_fix, r_fix;

   // Single shared iteration; the loop runs over time, not space.
   zm_div_step #(.XLEN(XLEN)) u_step (
      .rem_i  (rem_q),
      .dvd_i  (dvd_q),
      .dvs_i  (dvs_q),
      .rem_o  (step_rem),
      .dvd_o  (step_dvd),
      .qbit_o (step_qbit)
   );

   // Decode the incoming op and resolve the cases that skip iteration.
   always_comb begin
      is_signed = ~bus.funct3[0];
      is_rem    = bus.funct3[1];
      a_neg     = is_signed & bus.reg1[XLEN-1];
      b_neg     = is_signed & bus.reg2[XLEN-1];
      a_abs     = a_neg ? -bus.reg1 : bus.reg1;
      b_abs     = b_neg ? -bus.reg2 : bus.reg2;
      valid_op  = (bus.funct7 == F7_MULDIV) & bus.funct3[2];
      div0      = (bus.reg2 == '0);
      ovf       = is_signed & (bus.reg1 == MIN_NEG) & (bus.reg2 == '1);
      special   = ~valid_op | div0 | ovf;
      if (!valid_op) begin
         spec_res = '0;
      end else if (div0) begin
         spec_res = is_rem ? bus.reg1 : '1;
      end else begin
         spec_res = is_rem ? '0 : MIN_NEG;
      end
      accept = bus.start_valid & (state_q == IDLE) & ~bus.flush;
   end

   // Final iteration result with sign correction applied.
   always_comb begin
      q_raw = step_dvd | XLEN'(step_qbit);
      q_fix = ctl_q.neg_q ? -q_raw : q_raw;
      r_fix = ctl_q.neg_r ? -step_rem : step_rem;
   end

   // Next-state and datapath control.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      ctl_d   = ctl_q;
      out_d   = out_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               if (special) begin
                  out_d   = spec_res;
                  state_d = DONE;
               end else begin
                  cnt_d        = '0;
                  rem_d        = '0;
                  dvd_d        = a_abs;
                  dvs_d        = b_abs;
                  ctl_d.neg_q  = a_neg ^ b_neg;
                  ctl_d.neg_r  = a_neg;
                  ctl_d.is_rem = is_rem;
                  state_d      = CALC;
               end
            end
         end
         CALC: begin
            if (bus.flush) begin
               state_d = IDLE;
            end else begin
               rem_d = step_rem;
               dvd_d = q_raw;  // quotient bits fill in behind the dividend
               cnt_d = CNT_W'(cnt_q + 1'b1);
               if (cnt_q == LAST_IT) begin
                  out_d   = ctl_q.is_rem ? r_fix : q_fix;
                  state_d = DONE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, datapath and registered status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         ctl_q   <= '0;
         out_q   <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         ctl_q   <= ctl_d;
         out_q   <= out_d;
         done_q  <= (state_d == DONE);
         busy_q  <= (state_d != IDLE);
         ready_q <= (state_d == IDLE);
      end
   end

   assign bus.out         = out_q;
   assign bus.done        = done_q;
   assign bus.busy        = busy_q;
   assign bus.start_ready = ready_q;
endmodule

// File: tb/tb_zm_div.sv
// tb_zm_div: directed bench for zm_div with an arithmetic reference model
// and a per-cycle compare of done/busy/start_ready/out.
module tb_zm_div;
   import zm_pkg::*;

   localparam int unsigned XLEN = 32;
   localparam logic [6:0] F7 = 7'b0000001;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   zm_div_if #(.XLEN(XLEN)) bus ();
   zm_div #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_pass = 0;

   // Reference model state: expected completion edge and result.
   bit          m_check_en = 1'b0;
   bit          m_active = 1'b0;
   int          m_done_at = -1;
   logic [31:0] m_out = '0;
   logic [31:0] m_pending = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // RV32M result from plain arithmetic; special = resolved without iterating.
   function automatic logic [31:0] model(input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [31:0] a, input logic [31:0] b,
                                          output bit special);
      bit is_rem = f3[1];
      bit uns    = f3[0];
      int sa, sb;
      special = 1'b1;
      if (f7 != 7'b0000001 || !f3[2]) return 32'h0;
      if (b == 32'h0) return is_rem ? a : 32'hFFFF_FFFF;
      if (!uns && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return is_rem ? 32'h0 : 32'h8000_0000;
      special = 1'b0;
      if (uns) return is_rem ? (a % b) : (a / b);
      sa = $signed(a);
      sb = $signed(b);
      return is_rem ? 32'(sa % sb) : 32'(sa / sb);
   endfunction

   function automatic bit exp_busy();
      return m_active && (cyc <= m_done_at);
   endfunction

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      if (m_check_en) begin
         if (m_active && cyc == m_done_at) m_out = m_pending;
         chk("done", 32'(bus.done), 32'(m_active && cyc == m_done_at));
         chk("busy", 32'(bus.busy), 32'(exp_busy()));
         chk("start_ready", 32'(bus.start_ready), 32'(!exp_busy()));
         chk("out", bus.out, m_out);
      end
   end

   task automatic start_op(input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] a, input logic [31:0] b,
                           input bit hold, output int e0);
      bit idle_before, special, got;
      logic [31:0] res;
      got = 1'b0;
      e0  = -1;
      @(negedge clk);
      bus.start_valid = 1'b1;
      bus.funct3 = f3;
      bus.funct7 = f7;
      bus.reg1   = a;
      bus.reg2   = b;
      for (int k = 0; k < 100 && !got; k++) begin
         idle_before = !exp_busy();
         @(posedge clk);
         #1;
         if (idle_before) begin
            got       = 1'b1;
            e0        = cyc;
            res       = model(f3, f7, a, b, special);
            m_pending = res;
            m_active  = 1'b1;
            m_done_at = e0 + (special ? 0 : XLEN);
            if (!hold) bus.start_valid = 1'b0;
         end
      end
      if (!got) begin
         chk("accept_timeout", 32'(got), 32'd1);
         bus.start_valid = 1'b0;
      end
   endtask

   task automatic wait_done(input int e0, output logic [31:0] val, output int lat);
      bit seen = 1'b0;
      val = 'x;
      lat = -1;
      for (int k = 0; k < 60 && !seen; k++) begin
         @(negedge clk);
         if (bus.done) begin
            seen = 1'b1;
            val  = bus.out;
            lat  = cyc - e0 + 1;
         end
      end
   endtask

   task automatic op(input string name, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_val, input int exp_lat);
      int e0, lat;
      logic [31:0] v;
      start_op(f3, f7, a, b, 1'b0, e0);
      wait_done(e0, v, lat);
      chk({name, "_out"}, v, exp_val);
      chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      bus.start_valid = 1'b0;
      bus.flush = 1'b0;
      @(posedge clk);
      #1;
      m_active = 1'b0;
      m_out    = '0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      int e0, e1, lat, dc;
      logic [31:0] v;
      reset = 1'b1;
      bus.start_valid = 1'b0;
      bus.flush  = 1'b0;
      bus.funct3 = '0;
      bus.funct7 = '0;
      bus.reg1   = '0;
      bus.reg2   = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out", bus.out, 32'h0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_ready", 32'(bus.start_ready), 32'd1);
      @(negedge clk);
      reset = 1'b0;
      m_check_en = 1'b1;

      op("divu_100_7", F3_DIVU, F7, 32'd100, 32'd7, 32'd14, 33);
      op("remu_100_7", F3_REMU, F7, 32'd100, 32'd7, 32'd2, 33);
      op("div_m7_2", F3_DIV, F7, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
      op("rem_m7_2", F3_REM, F7, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
      op("div_7_m2", F3_DIV, F7, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
      op("rem_7_m2", F3_REM, F7, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
      op("div_m7_m2", F3_DIV, F7, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 33);
      op("divu_big", F3_DIVU, F7, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 33);
      op("remu_big", F3_REMU, F7, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 33);
      op("divu_min_m1", F3_DIVU, F7, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
      op("remu_min_m1", F3_REMU, F7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
      op("div_min_2", F3_DIV, F7, 32'h8000_0000, 32'd2, 32'hC000_0000, 33);
      op("divu_5_0", F3_DIVU, F7, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
      op("remu_5_0", F3_REMU, F7, 32'd5, 32'd0, 32'd5, 1);
      op("div_m7_0", F3_DIV, F7, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1);
      op("rem_m7_0", F3_REM, F7, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1);
      op("div_ovf", F3_DIV, F7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      op("rem_ovf", F3_REM, F7, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
      op("bad_f7", F3_DIVU, 7'b0000000, 32'd100, 32'd7, 32'd0, 1);
      op("bad_f3", 3'b000, F7, 32'd100, 32'd7, 32'd0, 1);
      op("rem_m7_m2", F3_REM, F7, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 33);

      // Flush during CALC: no done, ready next cycle, out unchanged.
      start_op(F3_DIVU, F7, 32'd100, 32'd7, 1'b0, e0);
      repeat (10) @(posedge clk);
      @(negedge clk);
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      m_active = 1'b0;
      @(negedge clk);
      bus.flush = 1'b0;
      chk("flush_ready", 32'(bus.start_ready), 32'd1);
      chk("flush_busy", 32'(bus.busy), 32'd0);
      chk("flush_out_kept", bus.out, 32'hFFFF_FFFF);
      dc = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) dc++;
      end
      chk("flush_no_done", 32'(dc), 32'd0);
      op("divu_9_3_after_flush", F3_DIVU, F7, 32'd9, 32'd3, 32'd3, 33);

      // Flush together with start in IDLE: start is dropped.
      @(negedge clk);
      bus.flush = 1'b1;
      bus.start_valid = 1'b1;
      bus.funct3 = F3_DIVU;
      bus.funct7 = F7;
      bus.reg1 = 32'd50;
      bus.reg2 = 32'd5;
      @(posedge clk);
      #1;
      chk("flush_start_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      bus.flush = 1'b0;
      bus.start_valid = 1'b0;

      // start_valid held through a busy op: next accept right after DONE.
      start_op(F3_DIVU, F7, 32'd100, 32'd7, 1'b1, e0);
      bus.reg1 = 32'd9;
      bus.reg2 = 32'd3;
      wait_done(e0, v, lat);
      chk("b2b_first_out", v, 32'd14);
      chk("b2b_first_lat", 32'(lat), 32'd33);
      start_op(F3_DIVU, F7, 32'd9, 32'd3, 1'b0, e1);
      chk("b2b_accept_gap", 32'(e1 - e0), 32'd34);
      wait_done(e1, v, lat);
      chk("b2b_second_out", v, 32'd3);

      // Reset mid-CALC discards the operation.
      start_op(F3_DIVU, F7, 32'd100, 32'd7, 1'b0, e0);
      repeat (5) @(posedge clk);
      do_reset();
      chk("midrst_out", bus.out, 32'h0);
      chk("midrst_done", 32'(bus.done), 32'd0);
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      dc = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) dc++;
      end
      chk("midrst_no_done", 32'(dc), 32'd0);
      op("divu_after_rst", F3_DIVU, F7, 32'd100, 32'd7, 32'd14, 33);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
